output_pkt_arbiter: RTL and testbench

OUTPUT_PKT_ARBITER -- requirements
Module: output_pkt_arbiter

---
 rtl/output_pkt_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_output_pkt_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/output_pkt_arbiter.sv
// output_pkt_arbiter: merges N_CH packet streams onto one output.
// Whole packets are granted round-robin and each accepted word is forwarded with one cycle of latency.
// Packets longer than MAX_PKT_WORDS are cut short, and the sticky err_pkt_len flag records it.
// Optional feature: define OUTPUT_PKT_ARB_HEADER_EN to put a header word (with a sequence number) in front of every packet.
module output_pkt_arbiter #(
   parameter int N_CH          = 4,
   parameter int WIDTH         = 64,
   parameter int MAX_PKT_WORDS = 256
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic [N_CH*WIDTH-1:0]     din,
   input  logic [N_CH-1:0]           wr_en,
   input  logic [N_CH-1:0]           pkt_end,
   output logic [N_CH-1:0]           full,
   output logic [WIDTH-1:0]          dout,
   output logic                      dout_wr_en,
   output logic                      dout_pkt_end,
   input  logic                      dout_full,
   output logic [$clog2(N_CH)-1:0]   grant_ch,
   output logic                      busy,
   output logic                      err_pkt_len
);

   localparam int CH_W = $clog2(N_CH);

`ifdef OUTPUT_PKT_ARB_HEADER_EN
   typedef enum logic [1:0] {IDLE, HEADER, PASS} state_t;
`else
   typedef enum logic [0:0] {IDLE, PASS} state_t;
`endif

   state_t            state_q, state_d;
   logic [CH_W-1:0]   grant_q, grant_d;
   logic [CH_W-1:0]   last_q, last_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0]  dout_q, dout_d;
   logic              dout_wr_q, dout_wr_d;
   logic              dout_pe_q, dout_pe_d;
   logic              err_q, err_d;
`ifdef OUTPUT_PKT_ARB_HEADER_EN
   logic [15:0]       seq_q, seq_d;
   logic [WIDTH-1:0]  hdr_word;
`endif

   logic [WIDTH-1:0]  ch_word;
   logic              ch_pe;
   logic              accept;
   logic [15:0]       cnt_inc;
   logic [CH_W-1:0]   rr_pick;
   logic              rr_hit;

   assign ch_word = din[int'(grant_q)*WIDTH +: WIDTH];
   assign ch_pe   = pkt_end[grant_q];
   assign accept  = wr_en[grant_q] && !full[grant_q];
   assign cnt_inc = cnt_q + 16'd1;

   // Backpressure: only the granted channel in PASS may write, and nothing may write during reset.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         full[i] = RESET || dout_full || !(state_q == PASS && grant_q == CH_W'(i));
      end
   end

   // Round-robin pick: the requester nearest after last_grant wins (scanned in reverse so the nearest is assigned last).
   always_comb begin
      rr_pick = '0;
      rr_hit  = 1'b0;
      for (int k = N_CH; k >= 1; k--) begin
         if (wr_en[(int'(last_q) + k) % N_CH]) begin
            rr_hit  = 1'b1;
            rr_pick = CH_W'((int'(last_q) + k) % N_CH);
         end
      end
   end

`ifdef OUTPUT_PKT_ARB_HEADER_EN
   // Header word layout: tag A5 in the top byte, sequence number in [31:16], channel in [15:8].
   always_comb begin
      hdr_word               = '0;
      hdr_word[31:16]        = seq_q;
      hdr_word[15:8]         = 8'(grant_q);
      hdr_word[WIDTH-1 -: 8] = 8'hA5;
   end
`endif

   // Next-state and datapath decisions for IDLE / (HEADER) / PASS.
   always_comb begin
      // NOTE: every signal gets a default before the case, so no path can leave one unassigned and infer a latch.
      state_d   = state_q;
      grant_d   = grant_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      dout_d    = dout_q;
      dout_wr_d = 1'b0;
      dout_pe_d = 1'b0;
      err_d     = err_q;
`ifdef OUTPUT_PKT_ARB_HEADER_EN
      seq_d     = seq_q;
`endif
      case (state_q)
         IDLE: begin
            if (rr_hit && !dout_full) begin
               grant_d = rr_pick;
               cnt_d   = 16'd0;
`ifdef OUTPUT_PKT_ARB_HEADER_EN
               state_d = HEADER;
`else
               state_d = PASS;
`endif
            end
         end
`ifdef OUTPUT_PKT_ARB_HEADER_EN
         HEADER: begin
            if (!dout_full) begin
               dout_d    = hdr_word;
               dout_wr_d = 1'b1;
               seq_d     = seq_q + 16'd1;
               state_d   = PASS;
            end
         end
`endif
         PASS: begin
            if (accept) begin
               dout_d    = ch_word;
               dout_wr_d = 1'b1;
               cnt_d     = cnt_inc;
               if (ch_pe) begin
                  dout_pe_d = 1'b1;
                  last_d    = grant_q;
                  state_d   = IDLE;
               end else if (cnt_inc == 16'(MAX_PKT_WORDS)) begin
                  // Overlong packet: close it here; the channel's remaining words start a new packet.
                  dout_pe_d = 1'b1;
                  err_d     = 1'b1;
                  state_d   = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      if (RESET) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         last_q    <= CH_W'(N_CH - 1);
         cnt_q     <= 16'd0;
         dout_q    <= '0;
         dout_wr_q <= 1'b0;
         dout_pe_q <= 1'b0;
         err_q     <= 1'b0;
`ifdef OUTPUT_PKT_ARB_HEADER_EN
         seq_q     <= 16'd0;
`endif
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         dout_q    <= dout_d;
         dout_wr_q <= dout_wr_d;
         dout_pe_q <= dout_pe_d;
         err_q     <= err_d;
`ifdef OUTPUT_PKT_ARB_HEADER_EN
         seq_q     <= seq_d;
`endif
      end
   end

   assign dout         = dout_q;
   assign dout_wr_en   = dout_wr_q;
   assign dout_pkt_end = dout_pe_q;
   assign grant_ch     = grant_q;
   assign busy         = (state_q != IDLE);
   assign err_pkt_len  = err_q;

endmodule

// File: tb/tb_output_pkt_arbiter.sv
// Testbench for output_pkt_arbiter: cycle-by-cycle vectors with hand-computed expected outputs.
// Inputs are driven just after the rising edge; outputs are sampled on the falling edge.
module tb_output_pkt_arbiter;

   localparam int N    = 4;
   localparam int W    = 64;
   localparam int MAXW = 4;

   logic           CLK;
   logic           RESET;
   logic [N*W-1:0] din;
   logic [N-1:0]   wr_en;
   logic [N-1:0]   pkt_end;
   logic [N-1:0]   full;
   logic [W-1:0]   dout;
   logic           dout_wr_en;
   logic           dout_pkt_end;
   logic           dout_full;
   logic [1:0]     grant_ch;
   logic           busy;
   logic           err_pkt_len;

   int checks   = 0;
   int failures = 0;
   int row      = 0;

   output_pkt_arbiter #(.N_CH(N), .WIDTH(W), .MAX_PKT_WORDS(MAXW)) dut (
      .CLK(CLK), .RESET(RESET), .din(din), .wr_en(wr_en), .pkt_end(pkt_end),
      .full(full), .dout(dout), .dout_wr_en(dout_wr_en), .dout_pkt_end(dout_pkt_end),
      .dout_full(dout_full), .grant_ch(grant_ch), .busy(busy), .err_pkt_len(err_pkt_len)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        rst;
      logic [3:0]  wr;
      logic [3:0]  pe;
      logic        df;
      logic [15:0] tag;
      logic [3:0]  x_full;
      logic        x_wr;
      logic        x_pe;
      logic        chk_d;
      logic [63:0] x_dout;
      logic [1:0]  x_grant;
      logic        x_busy;
      logic        x_err;
   } vec_t;

   vec_t vecs[$];

   // Data word that channel ch presents when the row tag is tag.
   function automatic logic [63:0] dw(input int ch, input logic [15:0] tag);
      return {16'hDA7A, 8'(ch), 8'h00, 16'h0000, tag};
   endfunction

   function automatic vec_t mk(input logic rst, input logic [3:0] wr, input logic [3:0] pe,
                               input logic df, input logic [15:0] tag, input logic [3:0] xf,
                               input logic xwr, input logic xpe, input logic chk,
                               input logic [63:0] xd, input logic [1:0] xg,
                               input logic xb, input logic xe);
      vec_t v;
      v.rst = rst; v.wr = wr; v.pe = pe; v.df = df; v.tag = tag;
      v.x_full = xf; v.x_wr = xwr; v.x_pe = xpe; v.chk_d = chk; v.x_dout = xd;
      v.x_grant = xg; v.x_busy = xb; v.x_err = xe;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One cycle: drive the inputs, sample on the falling edge, then advance past the next rising edge.
   task automatic run_vec(input vec_t v);
      RESET     = v.rst;
      wr_en     = v.wr;
      pkt_end   = v.pe;
      dout_full = v.df;
      for (int i = 0; i < N; i++) din[i*W +: W] = dw(i, v.tag);
      @(negedge CLK);
      check($sformatf("r%0d_full", row), 64'(full), 64'(v.x_full));
      check($sformatf("r%0d_wr_en", row), 64'(dout_wr_en), 64'(v.x_wr));
      check($sformatf("r%0d_pkt_end", row), 64'(dout_pkt_end), 64'(v.x_pe));
      check($sformatf("r%0d_grant", row), 64'(grant_ch), 64'(v.x_grant));
      check($sformatf("r%0d_busy", row), 64'(busy), 64'(v.x_busy));
      check($sformatf("r%0d_err", row), 64'(err_pkt_len), 64'(v.x_err));
      if (v.chk_d) check($sformatf("r%0d_dout", row), dout, v.x_dout);
      row++;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RESET = 1'b1; wr_en = '0; pkt_end = '0; dout_full = 1'b0; din = '0;
      repeat (2) @(posedge CLK);
      #1;

      // Reset state: registered outputs zero, full held all ones while RESET is high.
      vecs.push_back(mk(1, 4'h0, 4'h0, 0, 0, 4'hF, 0, 0, 1, 64'h0, 0, 0, 0));

`ifdef OUTPUT_PKT_ARB_HEADER_EN
      // ch2 then ch1, one data word each; a header precedes each packet.
      vecs.push_back(mk(0, 4'h4, 4'h4, 0, 60, 4'hF, 0, 0, 0, 64'h0, 0, 0, 0));
      vecs.push_back(mk(0, 4'h4, 4'h4, 0, 60, 4'hF, 0, 0, 0, 64'h0, 2, 1, 0));
      vecs.push_back(mk(0, 4'h4, 4'h4, 0, 60, 4'hB, 1, 0, 1, 64'hA500_0000_0000_0200, 2, 1, 0));
      vecs.push_back(mk(0, 4'h2, 4'h2, 0, 61, 4'hF, 1, 1, 1, dw(2, 60), 2, 0, 0));
      vecs.push_back(mk(0, 4'h2, 4'h2, 0, 61, 4'hF, 0, 0, 0, 64'h0, 1, 1, 0));
      vecs.push_back(mk(0, 4'h2, 4'h2, 0, 61, 4'hD, 1, 0, 1, 64'hA500_0000_0001_0100, 1, 1, 0));
      vecs.push_back(mk(0, 4'h0, 4'h0, 0, 0, 4'hF, 1, 1, 1, dw(1, 61), 1, 0, 0));
      foreach (vecs[i]) run_vec(vecs[i]);
`else
      // ch0 sends three words; the third carries pkt_end.
      vecs.push_back(mk(0, 4'h1, 4'h0, 0, 1, 4'hF, 0, 0, 0, 64'h0, 0, 0, 0));
      vecs.push_back(mk(0, 4'h1, 4'h0, 0, 1, 4'hE, 0, 0, 0, 64'h0, 0, 1, 0));
      vecs.push_back(mk(0, 4'h1, 4'h0, 0, 2, 4'hE, 1, 0, 1, dw(0, 1), 0, 1, 0));
      vecs.push_back(mk(0, 4'h1, 4'h1, 0, 3, 4'hE, 1, 0, 1, dw(0, 2), 0, 1, 0));
      vecs.push_back(mk(0, 4'h0, 4'h0, 0, 0, 4'hF, 1, 1, 1, dw(0, 3), 0, 0, 0));
      vecs.push_back(mk(0, 4'h0, 4'h0, 0, 0, 4'hF, 0, 0, 0, 64'h0, 0, 0, 0));
      // Reset, then all four channels request one-word packets: grants go 0,1,2,3,0.
      vecs.push_back(mk(1, 4'h0, 4'h0, 0, 0, 4'hF, 0, 0, 0, 64'h0, 0, 0, 0));
      vecs.push_back(mk(0, 4'hF, 4'hF, 0, 10, 4'hF, 0, 0, 0, 64'h0, 0, 0, 0));
      vecs.push_back(mk(0, 4'hF, 4'hF, 0, 11, 4'hE, 0, 0, 0, 64'h0, 0, 1, 0));
      vecs.push_back(mk(0, 4'hF, 4'hF, 0, 12, 4'hF, 1, 1, 1, dw(0, 11), 0, 0, 0));
      vecs.push_back(mk(0, 4'hF, 4'hF, 0, 13, 4'hD, 0, 0, 0, 64'h0, 1, 1, 0));
      vecs.push_back(mk(0, 4'hF, 4'hF, 0, 14, 4'hF, 1, 1, 1, dw(1, 13), 1, 0, 0));
      vecs.push_back(mk(0, 4'hF, 4'hF, 0, 15, 4'hB, 0, 0, 0, 64'h0, 2, 1, 0));
      vecs.push_back(mk(0, 4'hF, 4'hF, 0, 16, 4'hF, 1, 1, 1, dw(2, 15), 2, 0, 0));
      vecs.push_back(mk(0, 4'hF, 4'hF, 0, 17, 4'h7, 0, 0, 0, 64'h0, 3, 1, 0));
      vecs.push_back(mk(0, 4'hF, 4'hF, 0, 18, 4'hF, 1, 1, 1, dw(3, 17), 3, 0, 0));
      vecs.push_back(mk(0, 4'hF, 4'hF, 0, 19, 4'hE, 0, 0, 0, 64'h0, 0, 1, 0));
      vecs.push_back(mk(0, 4'h0, 4'h0, 0, 0, 4'hF, 1, 1, 1, dw(0, 19), 0, 0, 0));
      // ch1 streams six words without pkt_end (limit 4): forced end on word 4, err sticks, words 5-6 form a new packet.
      vecs.push_back(mk(0, 4'h2, 4'h0, 0, 20, 4'hF, 0, 0, 0, 64'h0, 0, 0, 0));
      vecs.push_back(mk(0, 4'h2, 4'h0, 0, 21, 4'hD, 0, 0, 0, 64'h0, 1, 1, 0));
      vecs.push_back(mk(0, 4'h2, 4'h0, 0, 22, 4'hD, 1, 0, 1, dw(1, 21), 1, 1, 0));
      vecs.push_back(mk(0, 4'h2, 4'h0, 0, 23, 4'hD, 1, 0, 1, dw(1, 22), 1, 1, 0));
      vecs.push_back(mk(0, 4'h2, 4'h0, 0, 24, 4'hD, 1, 0, 1, dw(1, 23), 1, 1, 0));
      vecs.push_back(mk(0, 4'h2, 4'h0, 0, 25, 4'hF, 1, 1, 1, dw(1, 24), 1, 0, 1));
      vecs.push_back(mk(0, 4'h2, 4'h0, 0, 25, 4'hD, 0, 0, 0, 64'h0, 1, 1, 1));
      vecs.push_back(mk(0, 4'h2, 4'h2, 0, 26, 4'hD, 1, 0, 1, dw(1, 25), 1, 1, 1));
      vecs.push_back(mk(0, 4'h0, 4'h0, 0, 0, 4'hF, 1, 1, 1, dw(1, 26), 1, 0, 1));
      // RESET on word 2 of a ch2 packet: everything clears, then ch0 beats ch2 for the next grant.
      vecs.push_back(mk(0, 4'h4, 4'h0, 0, 30, 4'hF, 0, 0, 0, 64'h0, 1, 0, 1));
      vecs.push_back(mk(0, 4'h4, 4'h0, 0, 31, 4'hB, 0, 0, 0, 64'h0, 2, 1, 1));
      vecs.push_back(mk(1, 4'h4, 4'h0, 0, 32, 4'hF, 1, 0, 1, dw(2, 31), 2, 1, 1));
      vecs.push_back(mk(0, 4'h5, 4'h5, 0, 33, 4'hF, 0, 0, 1, 64'h0, 0, 0, 0));
      vecs.push_back(mk(0, 4'h5, 4'h5, 0, 34, 4'hE, 0, 0, 0, 64'h0, 0, 1, 0));
      vecs.push_back(mk(0, 4'h0, 4'h0, 0, 0, 4'hF, 1, 1, 1, dw(0, 34), 0, 0, 0));
      foreach (vecs[i]) run_vec(vecs[i]);

      // Hand sequence: dout_full held for 5 cycles in the middle of a ch3 packet.
      run_vec(mk(0, 4'h8, 4'h0, 0, 40, 4'hF, 0, 0, 0, 64'h0, 0, 0, 0));
      run_vec(mk(0, 4'h8, 4'h0, 0, 41, 4'h7, 0, 0, 0, 64'h0, 3, 1, 0));
      run_vec(mk(0, 4'h8, 4'h0, 1, 42, 4'hF, 1, 0, 1, dw(3, 41), 3, 1, 0));
      for (int i = 0; i < 4; i++)
         run_vec(mk(0, 4'h8, 4'h0, 1, 42, 4'hF, 0, 0, 0, 64'h0, 3, 1, 0));
      run_vec(mk(0, 4'h8, 4'h0, 0, 42, 4'h7, 0, 0, 0, 64'h0, 3, 1, 0));
      run_vec(mk(0, 4'h8, 4'h8, 0, 43, 4'h7, 1, 0, 1, dw(3, 42), 3, 1, 0));
      run_vec(mk(0, 4'h0, 4'h0, 0, 0, 4'hF, 1, 1, 1, dw(3, 43), 3, 0, 0));

      // Hand sequence: no grant from IDLE while dout_full is high; the grant follows once it drops.
      for (int i = 0; i < 2; i++)
         run_vec(mk(0, 4'h1, 4'h1, 1, 50, 4'hF, 0, 0, 0, 64'h0, 3, 0, 0));
      run_vec(mk(0, 4'h1, 4'h1, 0, 50, 4'hF, 0, 0, 0, 64'h0, 3, 0, 0));
      run_vec(mk(0, 4'h1, 4'h1, 0, 50, 4'hE, 0, 0, 0, 64'h0, 0, 1, 0));
      run_vec(mk(0, 4'h0, 4'h0, 0, 0, 4'hF, 1, 1, 1, dw(0, 50), 0, 0, 0));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
